// File: rtl/arm_pkg.sv
// Shared definitions for the MMC arm dead-time generator.
// Leg state encodings and default arm widths.
package arm_pkg;

    localparam int N_LEGS = 4;
    localparam int DT_W   = 8;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_LO_ON,
        ST_HI_ON,
        ST_DT
    } leg_state_t;

endpackage

// File: rtl/arm_deadtime_if.sv
// Command/gate bundle between arm_balance side and the dead-time block.
// master drives commands, slave returns gates.
interface arm_deadtime_if;
    import arm_pkg::*;

    logic              enable;
    logic [DT_W-1:0]   dt_cycles;
    logic [N_LEGS-1:0] Fo;
    logic [N_LEGS-1:0] gate_hi;
    logic [N_LEGS-1:0] gate_lo;
    logic [N_LEGS-1:0] dt_active;

    modport master (
        output enable, dt_cycles, Fo,
        input  gate_hi, gate_lo, dt_active
    );

    modport slave (
        input  enable, dt_cycles, Fo,
        output gate_hi, gate_lo, dt_active
    );

endinterface

// File: rtl/arm_deadtime_leg.sv
// One leg: complementary gate FSM with a down-counted both-off interval.
// Gate outputs are registered from the next state so they never glitch.
module arm_deadtime_leg
    import arm_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [DT_W-1:0] dt_cycles,
    input  logic            fo,
    output logic            gate_hi,
    output logic            gate_lo,
    output logic            dt_active
);

    leg_state_t      state;
    leg_state_t      state_nx;
    logic [DT_W-1:0] cnt;
    logic [DT_W-1:0] cnt_nx;
    logic [DT_W-1:0] d_m1;

    // A zero dead time still gets one full both-off cycle.
    assign d_m1 = (dt_cycles == '0) ? '0 : dt_cycles - 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_OFF;
            cnt       <= '0;
            gate_hi   <= 1'b0;
            gate_lo   <= 1'b0;
            dt_active <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            gate_hi   <= (state_nx == ST_HI_ON);
            gate_lo   <= (state_nx == ST_LO_ON);
            dt_active <= (state_nx == ST_DT);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (!enable) begin
            state_nx = ST_OFF;
            cnt_nx   = '0;
        end else begin
            unique case (state)
                ST_OFF: begin
                    state_nx = ST_DT;
                    cnt_nx   = d_m1;
                end
                ST_LO_ON: begin
                    if (fo) begin
                        state_nx = ST_DT;
                        cnt_nx   = d_m1;
                    end
                end
                ST_HI_ON: begin
                    if (!fo) begin
                        state_nx = ST_DT;
                        cnt_nx   = d_m1;
                    end
                end
                ST_DT: begin
                    if (cnt == '0) begin
                        state_nx = fo ? ST_HI_ON : ST_LO_ON;
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
                default: begin
                    state_nx = ST_OFF;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/arm_deadtime.sv
// Dead-time generator for one MMC arm: N_LEGS independent leg FSMs
// sharing enable and dead-time setting.
module arm_deadtime
    import arm_pkg::*;
(
    input logic           clk,
    input logic           rst,
    arm_deadtime_if.slave bus
);

    logic [N_LEGS-1:0] hi;
    logic [N_LEGS-1:0] lo;
    logic [N_LEGS-1:0] act;

    for (genvar i = 0; i < N_LEGS; i++) begin : g_leg
        arm_deadtime_leg u_leg (
            .clk       (clk),
            .rst       (rst),
            .enable    (bus.enable),
            .dt_cycles (bus.dt_cycles),
            .fo        (bus.Fo[i]),
            .gate_hi   (hi[i]),
            .gate_lo   (lo[i]),
            .dt_active (act[i])
        );
    end

    assign bus.gate_hi   = hi;
    assign bus.gate_lo   = lo;
    assign bus.dt_active = act;

endmodule
